nes_pad_responder: RTL and testbench

- Device end of the NES serial pad protocol: presents an 8-button state to a pad reader (latch / pad clock / data) exactly as a 4021-based NES pad would.
- Used in two places:
  - as the bus-functional model that `controller` verification benches run against;
  - on-chip, to feed a scripted or CPU-driven "player" into a reader port without a physical pad.
- Latch and pad-clock inputs are treated as asynchronous and synchronised internally.

---
 rtl/nes_pad_responder_if.sv | 26 ++
 rtl/nes_pad_responder.sv | 147 ++++++++++++++
 tb/tb_nes_pad_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/nes_pad_responder_if.sv
// nes_pad_responder_if
//   Serial NES pad wire bundle between a pad reader and a pad device.
//   Signals:
//     latch_in   - latch strobe from the reader, active-high
//     pad_clk_in - pad clock from the reader, rising edge advances the shift
//     data_out   - serial button data from the pad, active-low
//   Modports:
//     master - the reader side (drives latch and pad clock)
//     slave  - the pad side (drives serial data)
interface nes_pad_responder_if;
  logic latch_in;
  logic pad_clk_in;
  logic data_out;

  modport master (
    output latch_in,
    output pad_clk_in,
    input  data_out
  );

  modport slave (
    input  latch_in,
    input  pad_clk_in,
    output data_out
  );
endinterface

// File: rtl/nes_pad_responder.sv
// nes_pad_responder
//   Device end of the NES serial pad protocol. Presents an 8-button state to
//   a pad reader exactly as a 4021-based pad would: the latch parallel-loads
//   the buttons, each pad clock rising edge shifts the next button out, and
//   after eight bits the line rests at the tail level.
//   Ports:
//     clk          - system clock
//     reset        - asynchronous active-high reset
//     buttons_in   - button state, 1 = pressed (bit7 A ... bit0 Right)
//     pad          - serial pad bundle (slave side): latch, pad clock, data
//     bit_index    - bit currently on the data line, 0..7, or 8 in the tail
//     frame_done   - one-cycle pulse when the 8th button bit is shifted out
//     extra_clocks - saturating count of pad clocks seen in the tail
//     busy         - high while loading or shifting
module nes_pad_responder #(
  parameter int SYNC_STAGES = 2,
  parameter bit TAIL_BIT    = 1'b0,
  parameter bit IDLE_BIT    = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                buttons_in,
  nes_pad_responder_if.slave        pad,
  output logic [3:0]                bit_index,
  output logic                      frame_done,
  output logic [3:0]                extra_clocks,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    TAIL
  } state_t;

  state_t                 state;
  logic [7:0]             shreg;
  logic                   data_q;
  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   l_s;
  logic                   c_s;
  logic                   l_prev;
  logic                   c_prev;
  logic                   c_rise;
  logic                   l_fall;

  assign l_s    = latch_sync[SYNC_STAGES-1];
  assign c_s    = clk_sync[SYNC_STAGES-1];
  assign c_rise = c_s & ~c_prev;
  assign l_fall = ~l_s & l_prev;

  assign pad.data_out = data_q;
  assign busy         = (state == LOAD) || (state == SHIFT);

  // The reader's latch and pad clock are unrelated to clk, so both are run
  // through a flop chain before use. The extra "prev" flop behind each chain
  // gives a clean one-cycle edge strobe for the pad clock and latch release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_sync <= '0;
      clk_sync   <= '0;
      l_prev     <= 1'b0;
      c_prev     <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], pad.latch_in};
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], pad.pad_clk_in};
      l_prev     <= l_s;
      c_prev     <= c_s;
    end
  end

  // Pad state machine. data_q is loaded with the value the shift register
  // is about to present (shreg[6] on a shift rather than shreg[7]) so the
  // wire changes in the same cycle the shift happens, not one cycle later.
  // A high latch always wins over a coinciding pad clock edge, matching the
  // 4021, whose parallel-load input overrides its serial clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= 8'hFF;
      data_q       <= IDLE_BIT;
      bit_index    <= 4'd0;
      frame_done   <= 1'b0;
      extra_clocks <= 4'd0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          data_q <= IDLE_BIT;
          if (l_s) begin
            state        <= LOAD;
            bit_index    <= 4'd0;
            extra_clocks <= 4'd0;
          end
        end

        LOAD: begin
          // Transparent while the latch is high: the last value loaded
          // before the latch falls is the frame that gets shifted out.
          bit_index <= 4'd0;
          if (l_fall) begin
            state <= SHIFT;
          end else begin
            shreg  <= ~buttons_in;
            data_q <= ~buttons_in[7];
          end
        end

        SHIFT: begin
          if (l_s) begin
            state        <= LOAD;
            bit_index    <= 4'd0;
            extra_clocks <= 4'd0;
          end else if (c_rise) begin
            shreg     <= {shreg[6:0], TAIL_BIT};
            bit_index <= bit_index + 4'd1;
            if (bit_index == 4'd7) begin
              frame_done <= 1'b1;
              state      <= TAIL;
              data_q     <= TAIL_BIT;
            end else begin
              data_q <= shreg[6];
            end
          end
        end

        TAIL: begin
          data_q <= TAIL_BIT;
          if (l_s) begin
            state        <= LOAD;
            bit_index    <= 4'd0;
            extra_clocks <= 4'd0;
          end else if (c_rise && (extra_clocks != 4'd15)) begin
            extra_clocks <= extra_clocks + 4'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_responder.sv
// tb_nes_pad_responder
//   Self-checking bench for nes_pad_responder. Acts as a pad reader on the
//   serial bundle, runs a table of hand-computed frames, then a few
//   hand-written multi-cycle sequences (reset mid-frame, long latch,
//   tail saturation) and a full 8'h00..8'hFF reader loopback sweep.
module tb_nes_pad_responder;

  logic       clk;
  logic       reset;
  logic [7:0] buttons_in;
  logic [3:0] bit_index;
  logic       frame_done;
  logic [3:0] extra_clocks;
  logic       busy;

  int tests_run;
  int tests_failed;
  int done_count;

  nes_pad_responder_if pad_bus ();

  nes_pad_responder dut (
    .clk          (clk),
    .reset        (reset),
    .buttons_in   (buttons_in),
    .pad          (pad_bus),
    .bit_index    (bit_index),
    .frame_done   (frame_done),
    .extra_clocks (extra_clocks),
    .busy         (busy)
  );

  typedef struct {
    logic [7:0] buttons;
    int         nclk;
    logic [7:0] exp_bits;
    int         exp_done;
    logic [3:0] exp_extra;
    logic [3:0] exp_index;
    logic       exp_busy;
  } frame_vec_t;

  frame_vec_t vecs [6];

  // Free-running system clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_done pulses, sampled on the falling edge away from updates.
  always @(negedge clk) begin
    if (frame_done) done_count = done_count + 1;
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    tests_run = tests_run + 1;
    if (actual !== expected) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Latch pulse of six clk cycles, then time for the release to reach SHIFT.
  task automatic pulse_latch();
    pad_bus.latch_in = 1'b1;
    repeat (6) @(posedge clk);
    #2 pad_bus.latch_in = 1'b0;
    repeat (6) @(posedge clk);
    #2;
  endtask

  // One pad clock period; returns half_cycles*2 clk cycles after the rise.
  task automatic pad_clock(input int half_cycles);
    pad_bus.pad_clk_in = 1'b1;
    repeat (half_cycles) @(posedge clk);
    #2 pad_bus.pad_clk_in = 1'b0;
    repeat (half_cycles) @(posedge clk);
    #2;
  endtask

  // Run one frame from a vector: latch, nclk pad clocks 12 clk apart, check
  // every data bit on the wire, then the frame status outputs.
  task automatic applyStimulus(input frame_vec_t v, input string tag);
    logic exp_bit;
    done_count = 0;
    buttons_in = v.buttons;
    pulse_latch();
    checkOutput($sformatf("%s_bit0", tag), {7'd0, pad_bus.data_out}, {7'd0, v.exp_bits[7]});
    for (int k = 1; k <= v.nclk; k++) begin
      pad_clock(6);
      exp_bit = (k < 8) ? v.exp_bits[7-k] : 1'b0;
      checkOutput($sformatf("%s_bit%0d", tag, k), {7'd0, pad_bus.data_out}, {7'd0, exp_bit});
    end
    checkOutput($sformatf("%s_done", tag), done_count[7:0], v.exp_done[7:0]);
    checkOutput($sformatf("%s_extra", tag), {4'd0, extra_clocks}, {4'd0, v.exp_extra});
    checkOutput($sformatf("%s_index", tag), {4'd0, bit_index}, {4'd0, v.exp_index});
    checkOutput($sformatf("%s_busy", tag), {7'd0, busy}, {7'd0, v.exp_busy});
  endtask

  initial begin
    logic [7:0] rx;
    frame_vec_t v;

    tests_run    = 0;
    tests_failed = 0;
    done_count   = 0;

    // Hand-computed frames: exp_bits lists the wire levels MSB first
    // (A first), i.e. the bitwise inverse of the buttons pressed.
    vecs[0] = '{buttons: 8'h81, nclk: 8,  exp_bits: 8'h7E, exp_done: 1, exp_extra: 4'd0, exp_index: 4'd8, exp_busy: 1'b0};
    vecs[1] = '{buttons: 8'hFF, nclk: 11, exp_bits: 8'h00, exp_done: 1, exp_extra: 4'd3, exp_index: 4'd8, exp_busy: 1'b0};
    vecs[2] = '{buttons: 8'h00, nclk: 8,  exp_bits: 8'hFF, exp_done: 1, exp_extra: 4'd0, exp_index: 4'd8, exp_busy: 1'b0};
    vecs[3] = '{buttons: 8'hA5, nclk: 9,  exp_bits: 8'h5A, exp_done: 1, exp_extra: 4'd1, exp_index: 4'd8, exp_busy: 1'b0};
    vecs[4] = '{buttons: 8'h3C, nclk: 5,  exp_bits: 8'hC3, exp_done: 0, exp_extra: 4'd0, exp_index: 4'd5, exp_busy: 1'b1};
    vecs[5] = '{buttons: 8'h40, nclk: 8,  exp_bits: 8'hBF, exp_done: 1, exp_extra: 4'd0, exp_index: 4'd8, exp_busy: 1'b0};

    reset              = 1'b1;
    buttons_in         = 8'h00;
    pad_bus.latch_in   = 1'b0;
    pad_bus.pad_clk_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    // Reset state.
    checkOutput("reset_data",  {7'd0, pad_bus.data_out}, 8'd1);
    checkOutput("reset_index", {4'd0, bit_index}, 8'd0);
    checkOutput("reset_done",  {7'd0, frame_done}, 8'd0);
    checkOutput("reset_extra", {4'd0, extra_clocks}, 8'd0);
    checkOutput("reset_busy",  {7'd0, busy}, 8'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("idle_data", {7'd0, pad_bus.data_out}, 8'd1);

    // Reset asserted mid-SHIFT at bit_index 4 takes effect immediately.
    buttons_in = 8'h81;
    pulse_latch();
    for (int k = 0; k < 4; k++) pad_clock(6);
    checkOutput("midshift_index", {4'd0, bit_index}, 8'd4);
    checkOutput("midshift_busy",  {7'd0, busy}, 8'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_reset_data",  {7'd0, pad_bus.data_out}, 8'd1);
    checkOutput("async_reset_index", {4'd0, bit_index}, 8'd0);
    checkOutput("async_reset_busy",  {7'd0, busy}, 8'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2;

    // Table-driven frames; the first also shows a clean frame after reset,
    // row 4 is left mid-frame and row 5 relatches over it.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], $sformatf("row%0d", i));
    end

    // Tail saturation: 11 clocks gives 3 extra, 20 more saturate at 15,
    // the next latch clears the count.
    v = '{buttons: 8'hFF, nclk: 11, exp_bits: 8'h00, exp_done: 1, exp_extra: 4'd3, exp_index: 4'd8, exp_busy: 1'b0};
    applyStimulus(v, "sat");
    for (int k = 0; k < 20; k++) pad_clock(6);
    checkOutput("sat_extra15", {4'd0, extra_clocks}, 8'd15);
    checkOutput("sat_tail_data", {7'd0, pad_bus.data_out}, 8'd0);
    pulse_latch();
    checkOutput("sat_cleared", {4'd0, extra_clocks}, 8'd0);
    checkOutput("sat_relatch_index", {4'd0, bit_index}, 8'd0);

    // Long latch: transparent load tracks buttons, pad clocks are ignored.
    buttons_in       = 8'h00;
    pad_bus.latch_in = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    checkOutput("latch_hold_data1", {7'd0, pad_bus.data_out}, 8'd1);
    for (int k = 0; k < 3; k++) pad_clock(4);
    checkOutput("latch_hold_index", {4'd0, bit_index}, 8'd0);
    buttons_in = 8'h80;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("latch_hold_data0", {7'd0, pad_bus.data_out}, 8'd0);
    repeat (12) @(posedge clk);
    #2 pad_bus.latch_in = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    checkOutput("latch_release_index", {4'd0, bit_index}, 8'd0);
    checkOutput("latch_release_data",  {7'd0, pad_bus.data_out}, 8'd0);
    checkOutput("latch_release_busy",  {7'd0, busy}, 8'd1);

    // Reader loopback sweep: sample 8 clk cycles after each pad clock rise.
    for (int b = 0; b < 256; b++) begin
      buttons_in = b[7:0];
      pulse_latch();
      rx    = 8'h00;
      rx[7] = ~pad_bus.data_out;
      for (int k = 1; k < 8; k++) begin
        pad_clock(4);
        rx[7-k] = ~pad_bus.data_out;
      end
      pad_clock(4);
      checkOutput($sformatf("sweep_%02h", b), rx, b[7:0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
